// File: rtl/systolic_bs_array.sv
// systolic_bs_array: output-stationary ROWS x COLS bit-serial MAC array with input skew, job FSM and result drain.
// Define SYSTOLIC_SAT_EN for saturating accumulators and the sticky ovf output.
module systolic_bs_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_PREC = 8,
  localparam int IW = ROWS * COLS > 1 ? $clog2(ROWS * COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               k_len,
  input  logic [3:0]                precision,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*ACT_WIDTH-1:0] act_in,
  input  logic [COLS-1:0]           w_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [IW-1:0]             out_idx,
`ifdef SYSTOLIC_SAT_EN
  output logic                      ovf,
`endif
  output logic                      busy,
  output logic                      done
);
  localparam int BW = MAX_PREC > 1 ? $clog2(MAX_PREC) : 1;
  localparam int PW = $clog2(MAX_PREC + 1);
  localparam int WB = BW + 2;
  localparam int FW = $clog2(ROWS + COLS + 1);
  localparam int N = ROWS * COLS;
`ifdef SYSTOLIC_SAT_EN
  localparam int SW = ACC_WIDTH + ACT_WIDTH + MAX_PREC + 1;
  localparam logic signed [SW-1:0] AMAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`else
  localparam int SW = ACC_WIDTH;
`endif
  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_FEED = 3'd2, S_FLUSH = 3'd3, S_DRAIN = 3'd4;

  logic [2:0] state;
  logic [PW-1:0] prec_q;
  logic [15:0] kq, step;
  logic [BW-1:0] beat, plast;
  logic [FW-1:0] fl;
  logic [IW-1:0] idx;
  logic take, last_b;
  logic signed [ACT_WIDTH-1:0] act_e [ROWS];
  logic [WB-1:0] w_e [COLS];
  logic signed [ACT_WIDTH-1:0] a_h [ROWS][COLS];
  logic [WB-1:0] w_v [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_all [N];
`ifdef SYSTOLIC_SAT_EN
  logic ovf_all [N];
  assign ovf = out_valid ? ovf_all[idx] : 1'b0;
`endif

  assign plast = BW'(prec_q - PW'(1));
  assign last_b = beat == plast;
  assign take = in_valid && state == S_FEED;
  assign busy = state != S_IDLE;
  assign in_ready = state == S_FEED;
  assign out_valid = state == S_DRAIN;
  assign out_idx = idx;
  assign out_data = out_valid ? acc_all[idx] : '0;

  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      prec_q <= '0;
      kq <= '0;
      beat <= '0;
      step <= '0;
      fl <= '0;
      idx <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_CLEAR;
          kq <= k_len;
          prec_q <= (precision == 4'd0 || 32'(precision) > MAX_PREC) ? PW'(MAX_PREC) : PW'(precision);
        end
        S_CLEAR: begin
          state <= kq == 16'd0 ? S_FLUSH : S_FEED;
          beat <= '0;
          step <= '0;
          fl <= '0;
        end
        S_FEED: if (take) begin
          beat <= last_b ? '0 : beat + BW'(1);
          if (last_b) step <= step + 16'd1;
          if (last_b && step == kq - 16'd1) state <= S_FLUSH;
        end
        S_FLUSH: begin
          fl <= fl + FW'(1);
          if (fl == FW'(ROWS + COLS - 1)) begin
            state <= S_DRAIN;
            idx <= '0;
          end
        end
        S_DRAIN: if (out_ready) begin
          idx <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            state <= S_IDLE;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end

  // activations are captured on beat 0 and replayed from hold for the rest of the step
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic signed [ACT_WIDTH-1:0] hold;
    logic signed [ACT_WIDTH-1:0] sk [i+1];
    always_ff @(posedge clk)
      if (!rst) begin
        hold <= '0;
        for (int d = 0; d <= i; d++) sk[d] <= '0;
      end else begin
        if (take && beat == '0) hold <= act_in[i*ACT_WIDTH +: ACT_WIDTH];
        sk[0] <= beat == '0 ? act_in[i*ACT_WIDTH +: ACT_WIDTH] : hold;
        for (int d = 1; d <= i; d++) sk[d] <= sk[d-1];
      end
    assign act_e[i] = sk[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [WB-1:0] sk [j+1];
    always_ff @(posedge clk)
      if (!rst) begin
        for (int d = 0; d <= j; d++) sk[d] <= '0;
      end else begin
        sk[0] <= {take, beat, w_in[j]};
        for (int d = 1; d <= j; d++) sk[d] <= sk[d-1];
      end
    assign w_e[j] = sk[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pr
    for (genvar j = 0; j < COLS; j++) begin : g_pc
      logic signed [ACT_WIDTH-1:0] a_x, a_o;
      logic [WB-1:0] w_x, w_o;
      logic signed [ACC_WIDTH-1:0] acc, nxt;
      logic signed [SW-1:0] term, sum;
      if (j == 0) begin : g_a
        assign a_x = act_e[i];
      end else begin : g_a
        assign a_x = a_h[i][j-1];
      end
      if (i == 0) begin : g_w
        assign w_x = w_e[j];
      end else begin : g_w
        assign w_x = w_v[i-1][j];
      end
      // the top weight bit of a step carries negative weight
      assign term = SW'(a_x) <<< w_x[BW:1];
      assign sum = w_x[BW:1] == plast ? SW'(acc) - term : SW'(acc) + term;
`ifdef SYSTOLIC_SAT_EN
      logic ov_q;
      assign nxt = sum > AMAX ? AMAX[ACC_WIDTH-1:0] : sum < AMIN ? AMIN[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
      always_ff @(posedge clk)
        ov_q <= (!rst || state == S_CLEAR) ? 1'b0 : ov_q | (w_x[WB-1] & w_x[0] & (sum > AMAX || sum < AMIN));
      assign ovf_all[i*COLS+j] = ov_q;
`else
      assign nxt = sum;
`endif
      always_ff @(posedge clk)
        if (!rst) begin
          a_o <= '0;
          w_o <= '0;
          acc <= '0;
        end else begin
          a_o <= a_x;
          w_o <= w_x;
          acc <= state == S_CLEAR ? '0 : (w_x[WB-1] & w_x[0]) ? nxt : acc;
        end
      assign a_h[i][j] = a_o;
      assign w_v[i][j] = w_o;
      assign acc_all[i*COLS+j] = acc;
    end
  end
endmodule

// File: tb/tb_systolic_bs_array.sv
// tb_systolic_bs_array: randomized bench for the bit-serial systolic array, checked against a step-level arithmetic model.
`timescale 1ns/1ps
module tb_systolic_bs_array;
  logic clk = 0, rst = 0, start = 0, start16 = 0, in_valid = 0, out_ready = 0;
  logic [15:0] k_len = 0;
  logic [3:0] precision = 0;
  logic [63:0] act_in = 0;
  logic [3:0] w_in = 0;
  logic in_ready, out_valid, busy, done;
  logic [31:0] out_data;
  logic [3:0] out_idx;
  logic in_ready16, out_valid16, busy16, done16;
  logic [15:0] out_data16;
  logic [3:0] out_idx16;
`ifdef SYSTOLIC_SAT_EN
  logic ovf, ovf16;
`endif
  int checks = 0, failures = 0;
  int act_m [8][4];
  int w_m [8][4];
  longint got [16];

  always #5 clk = ~clk;

  systolic_bs_array u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .precision(precision),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
`ifdef SYSTOLIC_SAT_EN
    .ovf(ovf),
`endif
    .busy(busy), .done(done));

  systolic_bs_array #(.ACC_WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start16), .k_len(k_len), .precision(precision),
    .in_valid(in_valid), .in_ready(in_ready16), .act_in(act_in), .w_in(w_in),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_idx(out_idx16),
`ifdef SYSTOLIC_SAT_EN
    .ovf(ovf16),
`endif
    .busy(busy16), .done(done16));

  // result(i,j) = sum_k act[k][i] * signed P-bit weight[k][j]; saturating builds clamp after every bit-add
  function automatic longint model(int i, int j, int kl, int p, int aw);
    longint acc = 0;
    longint lim = longint'(1) << (aw - 1);
    for (int k = 0; k < kl; k++) begin
`ifdef SYSTOLIC_SAT_EN
      for (int b = 0; b < p; b++)
        if (w_m[k][j][b]) begin
          acc += (b == p - 1 ? -1 : 1) * (longint'(act_m[k][i]) << b);
          acc = acc >= lim ? lim - 1 : acc < -lim ? -lim : acc;
        end
`else
      acc += longint'(act_m[k][i]) * longint'(w_m[k][j] - ((w_m[k][j] >> (p - 1)) & 1) * (1 << p));
`endif
    end
`ifndef SYSTOLIC_SAT_EN
    acc = (acc << (64 - aw)) >>> (64 - aw);
`endif
    return acc;
  endfunction

  task automatic clear_m();
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 4; c++) begin
        act_m[k][c] = 0;
        w_m[k][c] = 0;
      end
  endtask

  task automatic rand_m(input int kl, input int p);
    for (int k = 0; k < kl; k++)
      for (int c = 0; c < 4; c++) begin
        act_m[k][c] = int'($signed(16'($urandom)));
        w_m[k][c] = int'($urandom) & ((1 << p) - 1);
      end
  endtask

  task automatic launch(input int kl, input int pr);
    k_len = 16'(kl);
    precision = 4'(pr);
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // bub<0 selects the fixed 1,0,0 valid pattern, otherwise it is a bubble percentage
  task automatic feed(input int kl, input int p, input int bub, input int sel, output int ok);
    int k = 0, b = 0, cyc = 0;
    logic acc;
    ok = 1;
    while (k < kl) begin
      if (cyc > 4000) begin
        ok = 0;
        break;
      end
      in_valid = bub < 0 ? (cyc % 3 == 0) : ($urandom_range(0, 99) >= bub);
      for (int i = 0; i < 4; i++) act_in[i*16 +: 16] = b == 0 ? 16'(act_m[k][i]) : 16'($urandom);
      for (int j = 0; j < 4; j++) w_in[j] = w_m[k][j][b];
      if (!in_valid) w_in = 4'($urandom);
      acc = in_valid & (sel != 0 ? in_ready16 : in_ready);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        b++;
        if (b == p) begin
          b = 0;
          k++;
        end
      end
    end
    in_valid = 0;
  endtask

  task automatic collect(input int stall, output int oe, output int he, output int dk);
    int n = 0, st = 0, cyc = 0;
    logic [31:0] pd = 0;
    logic [3:0] pi = 0;
    logic held = 0;
    oe = 0;
    he = 0;
    while (n < 16 && cyc < 3000) begin
      if (out_valid) begin
        if (held && (out_data !== pd || out_idx !== pi)) he++;
        if (st < stall) begin
          out_ready = 0;
          st++;
          held = 1;
          pd = out_data;
          pi = out_idx;
        end else begin
          out_ready = 1;
          st = 0;
          held = 0;
          if (out_idx !== 4'(n)) oe++;
          got[n] = longint'($signed(out_data));
          n++;
        end
      end else out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 0;
    dk = (n == 16 && done === 1'b1 && busy === 1'b0) ? 1 : 0;
    @(posedge clk); #1;
    if (done !== 1'b0) dk = 0;
  endtask

  task automatic run_job(input int kl, input int pr, input int bub, input int stall,
                         output int fok, output int oe, output int he, output int dk);
    int pe = (pr == 0 || pr > 8) ? 8 : pr;
    launch(kl, pr);
    fok = 1;
    if (kl > 0) feed(kl, pe, bub, 0, fok);
    collect(stall, oe, he, dk);
  endtask

  task automatic test_reset;
    checks += 6;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    if (out_idx !== 4'd0) begin failures++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_single_step;
    int fok, oe, he, dk;
    clear_m();
    act_m[0][0] = 3;
    w_m[0][0] = 5;
    run_job(1, 4, 0, 0, fok, oe, he, dk);
    checks += 4;
    if (fok !== 1) begin failures++; $display("FAIL single_feed got=%0d exp=1", fok); end
    if (got[0] !== 64'sd15) begin failures++; $display("FAIL single_idx0 got=%0d exp=15", got[0]); end
    if (oe !== 0) begin failures++; $display("FAIL single_order got=%0d exp=0", oe); end
    if (dk !== 1) begin failures++; $display("FAIL single_done got=%0d exp=1", dk); end
    for (int n = 1; n < 16; n++) begin
      checks++;
      if (got[n] !== 0) begin failures++; $display("FAIL single_zero idx=%0d got=%0d exp=0", n, got[n]); end
    end
  endtask

  task automatic set_two_step();
    clear_m();
    act_m[0][1] = -2;
    act_m[1][1] = 5;
    w_m[0][2] = 7;
    w_m[1][2] = 13;
  endtask

  task automatic test_two_step;
    int fok, oe, he, dk;
    set_two_step();
    run_job(2, 4, 0, 0, fok, oe, he, dk);
    checks += 3;
    if (got[6] !== -64'sd29) begin failures++; $display("FAIL two_step_idx6 got=%0d exp=-29", got[6]); end
    if (fok !== 1 || oe !== 0) begin failures++; $display("FAIL two_step_flow got=%0d/%0d exp=1/0", fok, oe); end
    if (dk !== 1) begin failures++; $display("FAIL two_step_done got=%0d exp=1", dk); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (got[n] !== model(n / 4, n % 4, 2, 4, 32)) begin failures++; $display("FAIL two_step_word idx=%0d got=%0d exp=%0d", n, got[n], model(n / 4, n % 4, 2, 4, 32)); end
    end
  endtask

  task automatic test_stall;
    int fok, oe, he, dk;
    set_two_step();
    run_job(2, 4, -1, 3, fok, oe, he, dk);
    checks += 4;
    if (got[6] !== -64'sd29) begin failures++; $display("FAIL stall_idx6 got=%0d exp=-29", got[6]); end
    if (oe !== 0) begin failures++; $display("FAIL stall_order got=%0d exp=0", oe); end
    if (he !== 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", he); end
    if (fok !== 1 || dk !== 1) begin failures++; $display("FAIL stall_done got=%0d/%0d exp=1/1", fok, dk); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (got[n] !== model(n / 4, n % 4, 2, 4, 32)) begin failures++; $display("FAIL stall_word idx=%0d got=%0d exp=%0d", n, got[n], model(n / 4, n % 4, 2, 4, 32)); end
    end
  endtask

  task automatic test_zero_k;
    int oe, he, dk;
    rand_m(2, 4);
    launch(0, 4);
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL zero_k_busy got=%b exp=1", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL zero_k_in_ready got=%b exp=0", in_ready); end
    k_len = 16'd5;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    collect(0, oe, he, dk);
    checks += 3;
    if (dk !== 1) begin failures++; $display("FAIL zero_k_done got=%0d exp=1", dk); end
    if (oe !== 0) begin failures++; $display("FAIL zero_k_order got=%0d exp=0", oe); end
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_k_restart got=%b exp=0", busy); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (got[n] !== 0) begin failures++; $display("FAIL zero_k_word idx=%0d got=%0d exp=0", n, got[n]); end
    end
  endtask

  task automatic test_abort;
    int fok, oe, he, dk;
    launch(3, 4);
    in_valid = 1;
    act_in = {4{16'h7fff}};
    w_in = 4'hf;
    repeat (6) @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    @(posedge clk); #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    rst = 1;
    rand_m(2, 4);
    run_job(2, 4, 20, 1, fok, oe, he, dk);
    checks++;
    if (fok !== 1 || oe !== 0 || he !== 0 || dk !== 1) begin failures++; $display("FAIL abort_rerun_flow got=%0d%0d%0d%0d exp=1001", fok, oe, he, dk); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (got[n] !== model(n / 4, n % 4, 2, 4, 32)) begin failures++; $display("FAIL abort_word idx=%0d got=%0d exp=%0d", n, got[n], model(n / 4, n % 4, 2, 4, 32)); end
    end
  endtask

  task automatic test_random;
    int fok, oe, he, dk, kl, pr, pe;
    for (int t = 0; t < 5; t++) begin
      kl = $urandom_range(1, 5);
      pr = t == 0 ? 0 : t == 1 ? 12 : $urandom_range(1, 8);
      pe = (pr == 0 || pr > 8) ? 8 : pr;
      rand_m(kl, pe);
      run_job(kl, pr, 30, $urandom_range(0, 2), fok, oe, he, dk);
      checks++;
      if (fok !== 1 || oe !== 0 || he !== 0 || dk !== 1) begin failures++; $display("FAIL random_flow t=%0d got=%0d%0d%0d%0d exp=1001", t, fok, oe, he, dk); end
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (got[n] !== model(n / 4, n % 4, kl, pe, 32)) begin failures++; $display("FAIL random_word t=%0d p=%0d k=%0d idx=%0d got=%0d exp=%0d", t, pe, kl, n, got[n], model(n / 4, n % 4, kl, pe, 32)); end
      end
    end
  endtask

  task automatic test_sat;
    int fok, cyc = 0;
    longint d;
`ifdef SYSTOLIC_SAT_EN
    longint want = 32767;
`else
    longint want = -508;
`endif
    clear_m();
    for (int k = 0; k < 4; k++) begin
      act_m[k][0] = 32767;
      w_m[k][0] = 127;
    end
    k_len = 16'd4;
    precision = 4'd8;
    start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    feed(4, 8, 0, 1, fok);
    while (!out_valid16 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    d = longint'($signed(out_data16));
    checks += 4;
    if (fok !== 1 || out_valid16 !== 1'b1) begin failures++; $display("FAIL acc16_drain got=%0d/%b exp=1/1", fok, out_valid16); end
    if (out_idx16 !== 4'd0) begin failures++; $display("FAIL acc16_idx got=%0d exp=0", out_idx16); end
    if (d !== want) begin failures++; $display("FAIL acc16_pe0 got=%0d exp=%0d", d, want); end
    if (d !== model(0, 0, 4, 8, 16)) begin failures++; $display("FAIL acc16_model got=%0d exp=%0d", d, model(0, 0, 4, 8, 16)); end
`ifdef SYSTOLIC_SAT_EN
    checks++;
    if (ovf16 !== 1'b1) begin failures++; $display("FAIL acc16_ovf got=%b exp=1", ovf16); end
`endif
    out_ready = 1;
    cyc = 0;
    while (!done16 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 0;
    checks++;
    if (done16 !== 1'b1) begin failures++; $display("FAIL acc16_done got=%b exp=1", done16); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1;
    @(posedge clk); #1;
    test_single_step();
    test_two_step();
    test_stall();
    test_zero_k();
    test_abort();
    test_random();
    test_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_bs_array.md
Name: systolic_bs_array

Overview:
Parametrised output-stationary ROWS x COLS systolic array of bit-serial INT-weight x fixed-point-activation MAC cells. It includes its own input skewing, a sequencing FSM (clear / feed / flush / drain) and a valid/ready result drain port. It sits between the activation/weight staging buffers and the result writeback. It is the generalised next generation of the 2x2 square array: the array is rectangular, precision is a runtime choice, input has a handshake, and the block computes its own completion.

Parameters:
ROWS, 4, array rows (activation channels)
COLS, 4, array columns (weight channels)
ACT_WIDTH, 16, signed aligned-mantissa activation width
ACC_WIDTH, 32, signed per-PE accumulator width
MAX_PREC, 8, maximum weight bit-width (sets bit-index counter width)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
start  in  1  launch a job; sampled in IDLE only
k_len  in  16  reduction length in K-steps; sampled at start
precision  in  4  weight bits per K-step; sampled at start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
act_in  in  ROWS*ACT_WIDTH  row i at [i*ACT_WIDTH +: ACT_WIDTH], signed
w_in  in  COLS  one weight bit-plane, bit j belongs to column j
out_valid  out  1  result word valid
out_ready  in  1  result word consumed
out_data  out  ACC_WIDTH  accumulator of PE(i,j)
out_idx  out  clog2(ROWS*COLS)  index i*COLS+j
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last result is consumed

Behaviour:
- Reset (rst=0 at clk edge): FSM=IDLE; all accumulators, skew registers and counters cleared. Outputs: in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0. Reset mid-job aborts the job; no done pulse.
- Precision: latched at start. Values 0 or >MAX_PREC are clamped to MAX_PREC.
- Beat ordering: one K-step = P beats (P = latched precision). Beat b (0..P-1) carries weight bit b, LSB first. act_in is sampled on beat 0 of each step and held internally for the remaining beats; on beats 1..P-1 act_in is ignored.
- PE op on a valid beat with weight bit=1:
  - b<P-1: acc += sext(act)<<b.
  - b=P-1: acc -= sext(act)<<b (two's-complement MSB).
  - Arithmetic wraps modulo 2^ACC_WIDTH.
- Skew and flow: row i act is delayed i cycles; column j weight bit is delayed j cycles. A beat-valid tag and the bit index travel with the weight down each column. Every PE registers its act (rightward) and weight/tag (downward) outputs each cycle. A beat accepted in cycle t updates PE(i,j) at the end of cycle t+i+j+1.
- Stalls: in_valid=0 inserts a bubble (tag=0). Bubbles never modify accumulators, and the step/beat counters do not advance.
- FSM:
  - IDLE: start=1 -> CLEAR. start is ignored when busy.
  - CLEAR: 1 cycle; all accumulators set to 0. Next state FEED, or FLUSH if k_len=0.
  - FEED: in_ready=1. Counts k_len*P accepted beats. After the last accepted beat -> FLUSH.
  - FLUSH: exactly ROWS+COLS cycles, in_ready=0 -> DRAIN.
  - DRAIN: out_valid=1. Words are presented in row-major index order 0..ROWS*COLS-1. out_data and out_idx are held stable while out_ready=0. After the last word is accepted -> IDLE with done=1 for that cycle.
- in_ready=0 in every state except FEED.
- k_len=0: all outputs drain as 0.

Optional Feature:
SYSTOLIC_SAT_EN:
- When defined, each PE add/subtract saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] on signed overflow.
- A per-PE sticky overflow bit is kept, cleared in CLEAR.
- Extra output port ovf (1 bit) is valid alongside out_data during DRAIN.
- When undefined, arithmetic wraps and port ovf does not exist.

Test Plan:
1. P=4, k_len=1, act row0=3, w col0=0101b (bits 1,0,1,0 in beat order) -> out_idx 0 = 15; all other PEs 0; done pulses once.
2. P=4, k_len=2, row1 acts (-2, 5), col2 weights (7, 1101b=-3) -> idx 6 = -14 + -15 = -29.
3. Same as 2 with in_valid toggled 1,0,0,1... (bubbles) and out_ready low 3 cycles per word -> identical values, order 0..15, data held while stalled.
4. k_len=0, start -> FEED skipped; 16 words of 0; then done. Assert start while busy -> ignored.
5. rst=0 for one cycle during FEED -> busy=0, in_ready=0, out_valid=0 next cycle. New job afterwards gives correct results with no stale accumulation.
6. ACC_WIDTH=16, P=8, k_len=4, act=32767, w=127 on PE0 -> without SYSTOLIC_SAT_EN out_data=-508 (wrapped); with it out_data=32767 and ovf=1.
